// File: rtl/fibonacci_core.sv
// Fibonacci sequence generator stepping F(n) at a programmable prescaler rate, wrapping after F(44).
// Build option: define FIBONACCI_OVF_IRQ_EN to enable the ovf_irq wrap pulse (otherwise tied low).
module fibonacci_core #(
  parameter int CLOCK_WIDTH = 6
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic [CLOCK_WIDTH-1:0] clock_sel,
  input  logic                   switch,
  input  logic                   restart,
  output logic [29:0]            fib_val,
  output logic [5:0]             step_cnt,
  output logic                   running,
  output logic                   ovf_irq,
  output logic [37:0]            io_out,
  output logic [37:0]            io_oeb,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WRAP  = 2'd3
  } state_e;

  localparam logic [37:0] OEB_RESET  = {38{1'b1}};
  localparam logic [37:0] OEB_ACTIVE = 38'h00_0000_00FF;
  localparam logic [5:0]  WRAP_STEP  = 6'd44;

  state_e                 state_q, state_d;
  logic [29:0]            a_q, a_d;
  logic [29:0]            b_q, b_d;
  logic [5:0]             step_q, step_d;
  logic [CLOCK_WIDTH-1:0] div_q, div_d;
  logic [37:0]            oeb_q, oeb_d;

  logic [30:0]            sum;
  logic                   tick;
  logic                   div_over;
  logic [CLOCK_WIDTH-1:0] div_next;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign tick     = (clock_sel != '0) && (div_q == clock_sel - CLOCK_WIDTH'(1));
  assign div_over = (div_q >= clock_sel);
  // A shrunk or zero period clears the prescaler rather than producing a late tick.
  assign div_next = (tick || div_over) ? '0 : div_q + CLOCK_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    div_d   = div_q;
    oeb_d   = OEB_ACTIVE;
    if (restart) begin
      state_d = ST_SEED;
      div_d   = '0;
    end else begin
      case (state_q)
        ST_SEED: begin
          a_d     = 30'd0;
          b_d     = 30'd1;
          step_d  = 6'd0;
          div_d   = '0;
          state_d = switch ? ST_RUN : ST_PAUSE;
        end
        ST_RUN: begin
          if (!switch) begin
            state_d = ST_PAUSE;
            div_d   = '0;
          end else begin
            div_d = div_next;
            if (tick) begin
              a_d = b_q;
              if (sum[30]) begin
                step_d  = WRAP_STEP;
                state_d = ST_WRAP;
              end else begin
                b_d    = sum[29:0];
                step_d = step_q + 6'd1;
              end
            end
          end
        end
        ST_PAUSE: begin
          div_d = '0;
          // step_cnt sits at 44 only while a wrap is pending, so resume finishes it.
          if (switch) begin
            state_d = (step_q == WRAP_STEP) ? ST_WRAP : ST_RUN;
          end
        end
        ST_WRAP: begin
          if (!switch) begin
            state_d = ST_PAUSE;
            div_d   = '0;
          end else begin
            div_d = div_next;
            if (tick) begin
              a_d     = 30'd0;
              b_d     = 30'd1;
              step_d  = 6'd0;
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q <= ST_SEED;
      a_q     <= 30'd0;
      b_q     <= 30'd1;
      step_q  <= 6'd0;
      div_q   <= '0;
      oeb_q   <= OEB_RESET;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      div_q   <= div_d;
      oeb_q   <= oeb_d;
    end
  end

`ifdef FIBONACCI_OVF_IRQ_EN
  logic ovf_q, ovf_d;

  assign ovf_d = (state_q == ST_WRAP) && switch && tick && !restart;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_irq = ovf_q;
`else
  assign ovf_irq = 1'b0;
`endif

  assign fib_val   = a_q;
  assign step_cnt  = step_q;
  assign running   = (state_q == ST_RUN);
  assign io_out    = {a_q, 8'h00};
  assign io_oeb    = oeb_q;
  assign dbg_state = state_q;

endmodule
